mul_prod_accum: RTL and testbench

//  Downstream consumer of the 4x4 combinational multiplier product (8-bit).

---
 rtl/mul_prod_accum.sv | 118 +++++++++++
 tb/tb_mul_prod_accum.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_prod_accum.sv
// Accumulates LEN consecutive unsigned products into a frame sum held on out_valid/out_ready.
// Define ACC_SAT_EN to clamp the accumulator at 2^ACC_W-1 on overflow instead of wrapping.
module mul_prod_accum #(
   parameter int PROD_W = 8,
   parameter int LEN    = 4,
   parameter int ACC_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);
   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   typedef enum logic [0:0] {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [ACC_W-1:0] acc_r, acc_nxt_s, out_sum_r;
   logic [ACC_W:0]   sum_s;
   logic             ovf_r, ovf_nxt_s, out_ovf_r;
   logic             accept_s, last_s, release_s, in_ready_s;

   // State register; clr aborts back to collecting
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ACC;
      end else if (clr) begin
         state_r <= ACC;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      accept_s    = 1'b0;
      last_s      = 1'b0;
      release_s   = 1'b0;
      case (state_r)
         ACC: begin
            in_ready_s = ~clr;
            accept_s   = in_valid & ~clr;
            last_s     = accept_s & (cnt_r == CNT_LAST);
            if (last_s) state_nxt_s = HOLD;
            else        state_nxt_s = ACC;
         end
         HOLD: begin
            release_s = out_ready & ~clr;
            if (out_ready) state_nxt_s = ACC;
            else           state_nxt_s = HOLD;
         end
         default: state_nxt_s = ACC;
      endcase
   end

   // One extra bit on the add exposes the carry out of the accumulator
   always_comb begin
      sum_s     = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
      ovf_nxt_s = ovf_r | sum_s[ACC_W];
`ifdef ACC_SAT_EN
      if (ovf_nxt_s) acc_nxt_s = {ACC_W{1'b1}};
      else           acc_nxt_s = sum_s[ACC_W-1:0];
`else
      acc_nxt_s = sum_s[ACC_W-1:0];
`endif
   end

   // Accumulator, beat counter and registered frame result
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_r     <= {ACC_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         ovf_r     <= 1'b0;
         out_sum_r <= {ACC_W{1'b0}};
         out_ovf_r <= 1'b0;
      end else if (accept_s) begin
         acc_r <= acc_nxt_s;
         ovf_r <= ovf_nxt_s;
         if (last_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            out_sum_r <= acc_nxt_s;
            out_ovf_r <= ovf_nxt_s;
         end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
            out_sum_r <= out_sum_r;
            out_ovf_r <= out_ovf_r;
         end
      end else if (release_s) begin
         acc_r     <= {ACC_W{1'b0}};
         cnt_r     <= cnt_r;
         ovf_r     <= 1'b0;
         out_sum_r <= {ACC_W{1'b0}};
         out_ovf_r <= 1'b0;
      end else begin
         acc_r     <= acc_r;
         cnt_r     <= cnt_r;
         ovf_r     <= ovf_r;
         out_sum_r <= out_sum_r;
         out_ovf_r <= out_ovf_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = (state_r == HOLD);
   assign out_sum   = out_sum_r;
   assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mul_prod_accum.sv
// Scoreboard bench for mul_prod_accum: three instances (LEN=4, LEN=1, ACC_W=9) against a frame-sum model.
// Honours ACC_SAT_EN in the reference model when the macro is defined for the build.
module tb_mul_prod_accum;
   localparam int NI = 3;

   typedef struct {
      longint sum;
      bit     ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] clr, iv, ir, ov, orr, ovf;
   logic [7:0]    prod [NI];
   logic [9:0]    osum0, osum1;
   logic [8:0]    osum2;

   int     checks = 0;
   int     errors = 0;
   bit     chk_en = 1'b0;
   int     m_cnt  [NI];
   longint m_acc  [NI];
   bit     m_hold [NI];
   int     pops   [NI];
   exp_t   sbq    [NI][$];
   exp_t   mon_e;

   always #5 clk = ~clk;

   mul_prod_accum #(.PROD_W(8), .LEN(4), .ACC_W(10)) dut0 (
      .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_prod(prod[0]),
      .out_valid(ov[0]), .out_ready(orr[0]), .out_sum(osum0), .out_ovf(ovf[0]));
   mul_prod_accum #(.PROD_W(8), .LEN(1), .ACC_W(10)) dut1 (
      .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_prod(prod[1]),
      .out_valid(ov[1]), .out_ready(orr[1]), .out_sum(osum1), .out_ovf(ovf[1]));
   mul_prod_accum #(.PROD_W(8), .LEN(4), .ACC_W(9)) dut2 (
      .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_prod(prod[2]),
      .out_valid(ov[2]), .out_ready(orr[2]), .out_sum(osum2), .out_ovf(ovf[2]));

   function automatic int len_of(int k);
      return (k == 1) ? 1 : 4;
   endfunction

   function automatic longint max_of(int k);
      return (k == 2) ? 64'd511 : 64'd1023;
   endfunction

   function automatic longint sum_of(int k);
      case (k)
         0:       return longint'(osum0);
         1:       return longint'(osum1);
         default: return longint'(osum2);
      endcase
   endfunction

   task automatic cmp(input string name, input int k, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d got 0x%0h want 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Monitor: compare what the DUT shows, then advance the frame model across the coming edge
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (chk_en && !rst) begin
            cmp("in_ready", k, longint'(ir[k]), longint'(!m_hold[k] && !clr[k]));
            cmp("out_valid", k, longint'(ov[k]), longint'(m_hold[k]));
            if (ov[k]) begin
               if (sbq[k].size() == 0) begin
                  cmp("sb_nonempty", k, 64'd0, 64'd1);
               end else begin
                  cmp("out_sum", k, sum_of(k), sbq[k][0].sum);
                  cmp("out_ovf", k, longint'(ovf[k]), longint'(sbq[k][0].ovf));
               end
            end else begin
               cmp("idle_sum", k, sum_of(k), 64'd0);
               cmp("idle_ovf", k, longint'(ovf[k]), 64'd0);
            end
         end
         if (rst || clr[k]) begin
            m_cnt[k]  = 0;
            m_acc[k]  = 0;
            m_hold[k] = 1'b0;
            sbq[k].delete();
         end else if (m_hold[k]) begin
            if (orr[k]) begin
               m_hold[k] = 1'b0;
               if (sbq[k].size() != 0) void'(sbq[k].pop_front());
               pops[k]++;
            end
         end else if (iv[k]) begin
            m_acc[k] += longint'(prod[k]);
            m_cnt[k]++;
            if (m_cnt[k] == len_of(k)) begin
               mon_e.ovf = (m_acc[k] > max_of(k));
`ifdef ACC_SAT_EN
               mon_e.sum = mon_e.ovf ? max_of(k) : m_acc[k];
`else
               mon_e.sum = m_acc[k] % (max_of(k) + 1);
`endif
               sbq[k].push_back(mon_e);
               m_hold[k] = 1'b1;
               m_cnt[k]  = 0;
               m_acc[k]  = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] p);
      bit done;
      int n;
      done = 1'b0;
      n = 0;
      iv[k] = 1'b1;
      prod[k] = p;
      while (!done && n < 100) begin
         @(negedge clk);
         done = ir[k] && !rst;
         tick();
         n++;
      end
      iv[k] = 1'b0;
      cmp("send_accepted", k, longint'(done), 64'd1);
   endtask

   task automatic check_hold(input int k, input longint s, input bit o);
      @(negedge clk);
      cmp("hold_valid", k, longint'(ov[k]), 64'd1);
      cmp("hold_sum", k, sum_of(k), s);
      cmp("hold_ovf", k, longint'(ovf[k]), longint'(o));
      tick();
      orr[k] = 1'b1;
      tick();
      orr[k] = 1'b0;
   endtask

   task automatic frame4(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      send(k, a);
      send(k, b);
      send(k, c);
      send(k, d);
   endtask

   task automatic rand_run(input int k, input int frames);
      int base;
      int cyc;
      base = pops[k];
      cyc = 0;
      while ((pops[k] - base) < frames && cyc < 40000) begin
         tick();
         iv[k]   = 1'($urandom_range(0, 1));
         prod[k] = 8'($urandom);
         orr[k]  = 1'($urandom_range(0, 1));
         clr[k]  = ($urandom_range(0, 199) == 0);
         cyc++;
      end
      tick();
      iv[k] = 1'b0;
      orr[k] = 1'b0;
      clr[k] = 1'b0;
      cmp("rand_frames_done", k, longint'((pops[k] - base) >= frames), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      clr = '0;
      iv  = '0;
      orr = '0;
      for (int k = 0; k < NI; k++) prod[k] = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      cmp("rst_out_valid", 0, longint'(ov[0]), 64'd0);
      cmp("rst_out_sum", 0, sum_of(0), 64'd0);
      cmp("rst_in_ready", 0, longint'(ir[0]), 64'd1);
      tick();

      // basic frame
      frame4(0, 8'h10, 8'h20, 8'h30, 8'h40);
      check_hold(0, 64'h0A0, 1'b0);

      // backpressure with a waiting product
      frame4(0, 8'h10, 8'h20, 8'h30, 8'h40);
      iv[0] = 1'b1;
      prod[0] = 8'h05;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmp("bp_in_ready", 0, longint'(ir[0]), 64'd0);
         cmp("bp_sum", 0, sum_of(0), 64'h0A0);
         tick();
      end
      orr[0] = 1'b1;
      tick();
      orr[0] = 1'b0;
      frame4(0, 8'h05, 8'h05, 8'h05, 8'h05);
      check_hold(0, 64'h014, 1'b0);

      // maximum products, default and narrow accumulator
      frame4(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      check_hold(0, 64'h3FC, 1'b0);
      frame4(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
`ifdef ACC_SAT_EN
      check_hold(2, 64'h1FF, 1'b1);
`else
      check_hold(2, 64'h1FC, 1'b1);
`endif

      // reset mid-frame
      send(0, 8'h11);
      send(0, 8'h22);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      cmp("midrst_valid", 0, longint'(ov[0]), 64'd0);
      cmp("midrst_sum", 0, sum_of(0), 64'd0);
      tick();
      frame4(0, 8'h10, 8'h20, 8'h30, 8'h40);
      check_hold(0, 64'h0A0, 1'b0);

      // clr mid-frame with a product presented
      send(0, 8'h11);
      send(0, 8'h22);
      clr[0] = 1'b1;
      iv[0] = 1'b1;
      prod[0] = 8'h33;
      @(negedge clk);
      cmp("clr_in_ready", 0, longint'(ir[0]), 64'd0);
      tick();
      clr[0] = 1'b0;
      iv[0] = 1'b0;
      frame4(0, 8'h01, 8'h02, 8'h03, 8'h04);
      check_hold(0, 64'h00A, 1'b0);

      // randomized handshakes, LEN=4 and LEN=1 in parallel
      fork
         rand_run(0, 1000);
         rand_run(1, 1000);
      join
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
